// File: rtl/host_config_arbiter_if.sv
// Config-port bundle: NUM_REQ requester words in, one held config word out.
interface host_config_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 256
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_accept;
  logic                      out_config_valid;
  logic [DATA_W-1:0]         out_config_data;
  logic                      out_config_accept;
  logic [ID_W-1:0]           out_grant_id;
  logic [31:0]               cfg_words_accepted;

  modport slave (
    input  req_valid, req_data, out_config_accept,
    output req_accept, out_config_valid, out_config_data, out_grant_id, cfg_words_accepted
  );

  modport master (
    output req_valid, req_data, out_config_accept,
    input  req_accept, out_config_valid, out_config_data, out_grant_id, cfg_words_accepted
  );
endinterface

// File: rtl/host_config_arbiter.sv
// Round-robin arbiter with bounded burst tenure feeding a single held config word.
//   state | meaning
//   IDLE  | output register empty
//   HOLD  | word held, frozen until out_config_accept
module host_config_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  host_config_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   NUM_WIDE  = (ID_W + 1)'(NUM_REQ);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_id, cand, win_id, gid_q;
  logic [ID_W:0]      sum;
  logic [BC_W-1:0]    burst_cnt;
  logic               rr_found, cont, load_slot, grant;
  logic [DATA_W-1:0]  data_q, win_data;
  logic [31:0]        words_q;
  logic [NUM_REQ-1:0] accept_vec;

  // Round-robin scan starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    sum      = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (sum >= NUM_WIDE) sum = sum - NUM_WIDE;
      cand = sum[ID_W-1:0];
      if (!rr_found && bus.req_valid[cand]) begin
        rr_found = 1'b1;
        rr_id    = cand;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    load_slot  = (state == IDLE) || bus.out_config_accept;
    cont       = (state == HOLD) && (burst_cnt < BURST_MAX) && bus.req_valid[gid_q];
    win_id     = cont ? gid_q : rr_id;
    grant      = load_slot && !reset && (cont || rr_found);
    accept_vec = '0;
    if (load_slot) state_nxt = (cont || rr_found) ? HOLD : IDLE;
    if (grant) accept_vec[win_id] = 1'b1;
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) win_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      gid_q     <= '0;
      words_q   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      if ((state == HOLD) && bus.out_config_accept) words_q <= words_q + 32'd1;
      if (grant) begin
        data_q <= win_data;
        gid_q  <= win_id;
        // Continuation keeps rr_ptr pointing past the owner so it scans last next time.
        if (cont) begin
          burst_cnt <= burst_cnt + 1'b1;
        end else begin
          burst_cnt <= BC_W'(1);
          rr_ptr    <= (rr_id == LAST_ID) ? '0 : rr_id + 1'b1;
        end
      end
    end
  end

  assign bus.req_accept         = accept_vec;
  assign bus.out_config_valid   = (state == HOLD);
  assign bus.out_config_data    = data_q;
  assign bus.out_grant_id       = gid_q;
  assign bus.cfg_words_accepted = words_q;
endmodule

// File: tb/tb_host_config_arbiter.sv
// Bench for host_config_arbiter: directed scenarios plus randomized traffic vs a queue-level model.
module tb_host_config_arbiter;
  localparam int N  = 2;
  localparam int DW = 256;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  host_config_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();
  host_config_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(int i, int s);
    logic [31:0] w;
    w = {s[15:0], i[7:0], 8'h3C};
    return {8{w}};
  endfunction

  // ---------------- requester / consumer driver ----------------
  int  left [N];
  int  seq  [N];
  int  pv = 0;
  int  pacc = 0;
  bit  flush = 0;
  logic [N-1:0] acc_q;

  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.out_config_accept = 1'b0;
    for (int i = 0; i < N; i++) begin left[i] = 0; seq[i] = 0; end
  end

  always begin
    @(negedge clk);
    acc_q = bus.req_accept;
    @(posedge clk);
    #1;
    if (flush) begin
      bus.req_valid = '0;
      for (int i = 0; i < N; i++) seq[i] = 0;
      flush = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && acc_q[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && left[i] > 0 && int'($urandom_range(99)) < pv) begin
          bus.req_data[i*DW +: DW] = mk(i, seq[i]);
          seq[i]++;
          left[i]--;
          bus.req_valid[i] = 1'b1;
        end
      end
    end
    bus.out_config_accept = (int'($urandom_range(99)) < pacc);
  end

  // ---------------- behavioural model ----------------
  bit           m_hold = 0;
  logic [255:0] m_data = '0;
  int           m_gid = 0, m_rr = 0, m_burst = 0;
  logic [31:0]  m_cnt = '0;

  // Winner for this cycle: owner continues while its tenure lasts, else first valid from rr pointer.
  task automatic model_pick(input logic [N-1:0] v, input logic acc, output int w, output bit cont);
    w = -1;
    cont = 0;
    if (m_hold && !acc) return;
    if (m_hold && m_burst < MB && v[m_gid]) begin
      w = m_gid;
      cont = 1;
      return;
    end
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) begin
        w = (m_rr + k) % N;
        return;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    int  w;
    bit  cont;
    if (rst) begin
      m_hold = 0; m_data = '0; m_gid = 0; m_rr = 0; m_burst = 0; m_cnt = '0;
    end else begin
      model_pick(bus.req_valid, bus.out_config_accept, w, cont);
      if (m_hold && bus.out_config_accept) m_cnt = m_cnt + 32'd1;
      if (!m_hold || bus.out_config_accept) begin
        if (w >= 0) begin
          m_hold = 1;
          m_data = bus.req_data[w*DW +: DW];
          m_gid  = w;
          if (cont) m_burst++;
          else begin
            m_burst = 1;
            m_rr = (w + 1) % N;
          end
        end else begin
          m_hold = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    int w;
    bit cont;
    if (!rst) begin
      model_pick(bus.req_valid, bus.out_config_accept, w, cont);
      chk("req_accept", bus.req_accept, (w >= 0) ? (1 << w) : 0);
      chk("out_config_valid", bus.out_config_valid, m_hold);
      if (m_hold) begin
        chk("out_config_data", bus.out_config_data, m_data);
        chk("out_grant_id", bus.out_grant_id, m_gid);
      end
      chk("cfg_words_accepted", bus.cfg_words_accepted, m_cnt);
    end
  end

  // ---------------- output handshake log ----------------
  int           cyc = 0;
  int           log_gid [$];
  logic [255:0] log_data [$];
  int           log_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (!rst && bus.out_config_valid && bus.out_config_accept) begin
      log_gid.push_back(int'(bus.out_grant_id));
      log_data.push_back(bus.out_config_data);
      log_cyc.push_back(cyc);
    end
  end

  // ---------------- helpers ----------------
  task automatic start_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    flush = 1;
    pv = 0;
    pacc = 0;
    for (int i = 0; i < N; i++) left[i] = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    log_gid.delete();
    log_data.delete();
    log_cyc.delete();
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_log(int n, int budget, string name);
    int b = 0;
    while (log_gid.size() < n && b < budget) begin
      @(posedge clk);
      #2;
      b++;
    end
    chk(name, log_gid.size(), n);
  endtask

  task automatic wait_valid(int budget, string name);
    int b = 0;
    @(negedge clk);
    while (!bus.out_config_valid && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk(name, bus.out_config_valid, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d0;
    logic [31:0]  c0;
    int           exp_seq [13] = '{0,0,0,0,1,1,1,1,0,0,0,0,1};

    // Reset state, with a requester already presenting a word.
    start_reset();
    left[0] = 1;
    pv = 100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid_seen", bus.req_valid[0], 1'b1);
    chk("rst_req_accept", bus.req_accept, 2'b00);
    chk("rst_out_valid", bus.out_config_valid, 1'b0);
    chk("rst_out_data", bus.out_config_data, 256'd0);
    chk("rst_grant_id", bus.out_grant_id, 1'b0);
    chk("rst_count", bus.cfg_words_accepted, 32'd0);

    // Single requester, three words A,B,C back-to-back.
    start_reset();
    left[0] = 3; pv = 100; pacc = 100;
    release_reset();
    wait_log(3, 20, "t1_words");
    if (log_gid.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("t1_data", log_data[k], mk(0, k));
        chk("t1_gid", log_gid[k], 0);
      end
      chk("t1_gap01", log_cyc[1] - log_cyc[0], 1);
      chk("t1_gap12", log_cyc[2] - log_cyc[1], 1);
    end
    chk("t1_count", bus.cfg_words_accepted, 32'd3);

    // Two always-valid requesters: bursts of MAX_BURST alternate with no bubbles.
    start_reset();
    left[0] = 100; left[1] = 100; pv = 100; pacc = 100;
    release_reset();
    wait_log(13, 40, "t2_words");
    if (log_gid.size() >= 13) begin
      for (int k = 0; k < 13; k++) chk("t2_grant_seq", log_gid[k], exp_seq[k]);
      chk("t2_no_idle", log_cyc[12] - log_cyc[0], 12);
    end

    // Backpressure: word held 5 cycles with accept low.
    start_reset();
    left[0] = 2; pv = 100; pacc = 0;
    release_reset();
    wait_valid(10, "t3_first_valid");
    d0 = bus.out_config_data;
    c0 = bus.cfg_words_accepted;
    chk("t3_held_data", d0, mk(0, 0));
    chk("t3_count0", c0, 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", bus.out_config_valid, 1'b1);
      chk("t3_hold_data", bus.out_config_data, d0);
      chk("t3_hold_gid", bus.out_grant_id, 1'b0);
      chk("t3_hold_req_accept", bus.req_accept, 2'b00);
    end
    pacc = 100;
    repeat (2) @(negedge clk);
    chk("t3_count_after", bus.cfg_words_accepted, c0 + 32'd1);

    // Simultaneous requests right after reset: requester 0 first.
    start_reset();
    left[0] = 1; left[1] = 1; pv = 100; pacc = 100;
    release_reset();
    @(negedge clk);
    chk("t4_first_accept", bus.req_accept, 2'b01);
    wait_log(2, 10, "t4_words");
    if (log_gid.size() >= 2) begin
      chk("t4_gid0", log_gid[0], 0);
      chk("t4_gid1", log_gid[1], 1);
    end

    // Lone requester 1 with 6 words: tenure expires and is re-won without a gap.
    start_reset();
    left[1] = 6; pv = 100; pacc = 100;
    release_reset();
    wait_log(6, 20, "t5_words");
    if (log_gid.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t5_gid", log_gid[k], 1);
        chk("t5_data", log_data[k], mk(1, k));
      end
      chk("t5_back_to_back", log_cyc[5] - log_cyc[0], 5);
    end
    chk("t5_count", bus.cfg_words_accepted, 32'd6);

    // Reset while a word is held: word dropped, counter cleared, requester 0 first.
    start_reset();
    left[0] = 4; pv = 100; pacc = 100;
    release_reset();
    wait_log(2, 20, "t6_pre_words");
    pacc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_pre_valid", bus.out_config_valid, 1'b1);
    chk("t6_pre_data", bus.out_config_data, mk(0, 3));
    chk("t6_pre_count", bus.cfg_words_accepted, 32'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", bus.out_config_valid, 1'b0);
    chk("t6_async_req_accept", bus.req_accept, 2'b00);
    chk("t6_async_count", bus.cfg_words_accepted, 32'd0);
    left[0] = 1; left[1] = 2; pacc = 100;
    release_reset();
    wait_log(3, 20, "t6_post_words");
    if (log_gid.size() >= 3) begin
      chk("t6_post_gid0", log_gid[0], 0);
      chk("t6_post_data0", log_data[0], mk(0, 4));
      chk("t6_post_gid1", log_gid[1], 1);
    end
    chk("t6_post_count", bus.cfg_words_accepted, 32'd3);

    // Randomized traffic, checked every cycle against the model.
    start_reset();
    left[0] = 100000; left[1] = 100000; pv = 60; pacc = 60;
    release_reset();
    for (int b = 0; b < 30; b++) begin
      pv = int'($urandom_range(20, 100));
      pacc = int'($urandom_range(0, 100));
      repeat (50) @(posedge clk);
    end

    #7;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
